// File: rtl/sram_controller.sv
// sram_controller: single-word request/result responder for one asynchronous
// SRAM bank. It accepts a read or write in IDLE, drives the SRAM strobes with
// fixed parameterised timing, and returns a one-cycle done pulse. Read data is
// returned on res_din.
// Optional feature macro: SRAM_BYTE_ENABLE_EN adds the req_be_n input. That
// input is latched at accept and driven on sram_be_n for the whole write.
// All pin-facing outputs are registered from the next-state decode, so no
// combinational path exists from req_* to the board pins.
module sram_controller #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 32,
    parameter int WE_CYCLES   = 2,
    parameter int READ_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    input  logic [DATA_WIDTH-1:0]   req_dout,
    input  logic                    req_oe_n,
    input  logic                    req_we_n,
    input  logic                    req_den,
`ifdef SRAM_BYTE_ENABLE_EN
    input  logic [DATA_WIDTH/8-1:0] req_be_n,
`endif
    output logic                    res_done,
    output logic [DATA_WIDTH-1:0]   res_din,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    inout  wire  [DATA_WIDTH-1:0]   sram_data,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic [DATA_WIDTH/8-1:0] sram_be_n
);

    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int CNT_MAX = (WE_CYCLES > READ_CYCLES) ? WE_CYCLES : READ_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_WAIT,
        RD_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;

    logic                    w_write;
    logic                    w_read;
    logic                    w_accept;
    logic                    w_accept_wr;
    logic [BE_W-1:0]         w_wbe;

    logic                    w_ce_n;
    logic                    w_oe_n;
    logic                    w_we_n;
    logic [BE_W-1:0]         w_be_n;
    logic                    w_drive;
    logic                    w_done;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_drive;
    logic [DATA_WIDTH-1:0]   r_din;

    // Write wins when both strobes are requested; a write also needs bus permission.
    assign w_write     = ~req_we_n & req_den;
    assign w_read      = ~req_oe_n & ~w_write;
    assign w_accept    = (r_state == IDLE) && (w_write || w_read);
    assign w_accept_wr = (r_state == IDLE) && w_write;

`ifdef SRAM_BYTE_ENABLE_EN
    logic [BE_W-1:0] r_wbe;

    // Latch the write byte enables together with the rest of the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wbe <= '1;
        end else if (w_accept_wr) begin
            r_wbe <= req_be_n;
        end
    end

    // On the accept edge the latch is still loading, so take the request field directly.
    assign w_wbe = (r_state == IDLE) ? req_be_n : r_wbe;
`else
    assign w_wbe = '0;
`endif

    assign sram_addr = r_addr;
    assign sram_data = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
    assign res_din   = r_din;

    // State and strobe-timing counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state decode, then pin values for the state being entered.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_ce_n     = 1'b1;
        w_oe_n     = 1'b1;
        w_we_n     = 1'b1;
        w_be_n     = '1;
        w_drive    = 1'b0;
        w_done     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_write) begin
                    w_next = WR_SETUP;
                end else if (w_read) begin
                    w_next     = RD_WAIT;
                    w_cnt_next = RD_LOAD;
                end
            end
            WR_SETUP: begin
                w_next     = WR_PULSE;
                w_cnt_next = WE_LOAD;
            end
            WR_PULSE: begin
                if (r_cnt == '0) begin
                    w_next = WR_HOLD;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            WR_HOLD: begin
                w_next = IDLE;
            end
            RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = RD_DONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            RD_DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        case (w_next)
            WR_SETUP: begin
                w_ce_n  = 1'b0;
                w_be_n  = w_wbe;
                w_drive = 1'b1;
            end
            WR_PULSE: begin
                w_ce_n  = 1'b0;
                w_we_n  = 1'b0;
                w_be_n  = w_wbe;
                w_drive = 1'b1;
            end
            WR_HOLD: begin
                w_ce_n  = 1'b0;
                w_be_n  = w_wbe;
                w_drive = 1'b1;
                w_done  = 1'b1;
            end
            RD_WAIT: begin
                w_ce_n = 1'b0;
                w_oe_n = 1'b0;
                w_be_n = '0;
            end
            RD_DONE: begin
                w_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Registered pin strobes, bus drive enable and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= '1;
            r_drive   <= 1'b0;
            res_done  <= 1'b0;
        end else begin
            sram_ce_n <= w_ce_n;
            sram_oe_n <= w_oe_n;
            sram_we_n <= w_we_n;
            sram_be_n <= w_be_n;
            r_drive   <= w_drive;
            res_done  <= w_done;
        end
    end

    // Address latched at accept; it doubles as the registered address pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= req_address;
        end
    end

    // Write data latched at accept; it only reaches the bus while r_drive is set.
    always_ff @(posedge clk) begin
        if (w_accept_wr) begin
            r_wdata <= req_dout;
        end
    end

    // Capture SRAM data on the last read-wait edge; it holds until the next read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_din <= '0;
        end else if ((r_state == RD_WAIT) && (r_cnt == '0)) begin
            r_din <= sram_data;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed transactions with literal expectations,
// a renderer-style write stream, reset abort, and randomized requests. A
// schedule model predicts every cycle from the access timing rules.
module tb_sram_controller;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int WE = 2;
    localparam int RC = 2;

    logic          clk;
    logic          rst;
    logic [AW-1:0] req_address;
    logic [DW-1:0] req_dout;
    logic          req_oe_n;
    logic          req_we_n;
    logic          req_den;
`ifdef SRAM_BYTE_ENABLE_EN
    logic [3:0]    req_be_n;
`endif
    logic          res_done;
    logic [DW-1:0] res_din;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [3:0]    sram_be_n;

    sram_controller #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WE_CYCLES  (WE),
        .READ_CYCLES(RC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_address(req_address),
        .req_dout   (req_dout),
        .req_oe_n   (req_oe_n),
        .req_we_n   (req_we_n),
        .req_den    (req_den),
`ifdef SRAM_BYTE_ENABLE_EN
        .req_be_n   (req_be_n),
`endif
        .res_done   (res_done),
        .res_din    (res_din),
        .sram_addr  (sram_addr),
        .sram_data  (sram_data),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_be_n  (sram_be_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SRAM pin model ----------------
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem_rd(sram_addr) : {DW{1'bz}};

    initial begin
        forever begin
            @(negedge clk);
            if (rst && !sram_ce_n && !sram_we_n) mem[sram_addr] = sram_data;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic          ce, oe, we, done, drive, rdchk, rd_done, commit;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sched [int];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            cyc = 0;
    int            next_accept = 0;
    logic [DW-1:0] din_cur = '0;

    function automatic exp_t idle_exp();
        exp_t e;
        e.ce = 1; e.oe = 1; e.we = 1; e.done = 0; e.drive = 0; e.rdchk = 0;
        e.rd_done = 0; e.commit = 0; e.be = 4'hF; e.addr = '0; e.data = '0;
        return e;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    // Access scheduler: on an accept edge, lay out the whole access cycle by cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                next_accept = cyc + 1;
            end else if (cyc >= next_accept) begin
                logic wr, rd;
                logic [3:0] wbe;
                exp_t e;
                wr = !req_we_n && req_den;
                rd = !req_oe_n && !wr;
`ifdef SRAM_BYTE_ENABLE_EN
                wbe = req_be_n;
`else
                wbe = 4'h0;
`endif
                if (wr) begin
                    for (int i = 0; i <= WE + 1; i++) begin
                        e = idle_exp();
                        e.ce = 0; e.be = wbe; e.drive = 1;
                        e.we = (i >= 1 && i <= WE) ? 1'b0 : 1'b1;
                        e.addr = req_address; e.data = req_dout;
                        e.done = (i == WE + 1);
                        e.commit = (i == WE + 1);
                        sched[cyc + i] = e;
                    end
                    next_accept = cyc + WE + 3;
                end else if (rd) begin
                    for (int i = 0; i < RC; i++) begin
                        e = idle_exp();
                        e.ce = 0; e.oe = 0; e.be = 4'h0; e.rdchk = 1; e.addr = req_address;
                        sched[cyc + i] = e;
                    end
                    e = idle_exp();
                    e.done = 1; e.rd_done = 1; e.data = ref_rd(req_address);
                    sched[cyc + RC] = e;
                    next_accept = cyc + RC + 2;
                end
            end
        end
    end

    // Cycle compare against the schedule (idle values when nothing is scheduled).
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_ce_n", sram_ce_n, 1'b1);
                chk("rst_oe_n", sram_oe_n, 1'b1);
                chk("rst_we_n", sram_we_n, 1'b1);
                chk("rst_be_n", sram_be_n, 4'hF);
                chk("rst_addr", sram_addr, '0);
                chk("rst_done", res_done, 1'b0);
                chk("rst_din", res_din, '0);
                sched.delete();
                din_cur = '0;
            end else begin
                exp_t e;
                e = sched.exists(cyc) ? sched[cyc] : idle_exp();
                chk("ce_n", sram_ce_n, e.ce);
                chk("oe_n", sram_oe_n, e.oe);
                chk("we_n", sram_we_n, e.we);
                chk("be_n", sram_be_n, e.be);
                chk("done", res_done, e.done);
                if (e.drive) begin
                    chk("wr_addr", sram_addr, e.addr);
                    chk("wr_data", sram_data, e.data);
                end
                if (e.rdchk) chk("rd_addr", sram_addr, e.addr);
                if (e.rd_done) din_cur = e.data;
                if (e.commit) ref_mem[e.addr] = e.data;
                chk("din", res_din, din_cur);
                sched.delete(cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_idle();
        req_we_n = 1; req_oe_n = 1; req_den = 0;
    endtask

    task automatic do_access(input logic we_n, input logic oe_n, input logic den,
                             input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] be,
                             output int lat, output int wel, output int oel, output int cel);
        repeat (2) @(negedge clk);
        req_we_n = we_n; req_oe_n = oe_n; req_den = den; req_address = a; req_dout = d;
`ifdef SRAM_BYTE_ENABLE_EN
        req_be_n = be;
`else
        if (be != 4'h0) lat = 0;
`endif
        @(posedge clk);
        #1 set_idle();
        lat = 0; wel = 0; oel = 0; cel = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (!sram_we_n) wel++;
            if (!sram_oe_n) oel++;
            if (!sram_ce_n) cel++;
            if (res_done) break;
        end
    endtask

    logic [AW-1:0] pool [8];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wel, oel, cel, cnt, last_t;
        rst = 0;
        set_idle();
        req_address = '0;
        req_dout = '0;
`ifdef SRAM_BYTE_ENABLE_EN
        req_be_n = 4'hF;
`endif
        mem[20'h00042] = 32'h0F0F00FF;
        ref_mem[20'h00042] = 32'h0F0F00FF;
        repeat (2) @(negedge clk);
        #2 rst = 1;

        // Directed write
        do_access(0, 1, 1, 20'h00123, 32'hDEADBEEF, 4'h0, lat, wel, oel, cel);
        chk("wr_latency", lat, 4);
        chk("wr_we_low", wel, 2);
        chk("wr_ce_low", cel, 4);
        chk("wr_oe_low", oel, 0);
        chk("wr_mem", mem_rd(20'h00123), 32'hDEADBEEF);

        // Directed read of preloaded word
        do_access(1, 0, 0, 20'h00042, '0, 4'h0, lat, wel, oel, cel);
        chk("rd_latency", lat, 3);
        chk("rd_oe_low", oel, 2);
        chk("rd_data", res_din, 32'h0F0F00FF);

        // Read back the directed write
        do_access(1, 0, 1, 20'h00123, '0, 4'h0, lat, wel, oel, cel);
        chk("rdback_data", res_din, 32'hDEADBEEF);

`ifdef SRAM_BYTE_ENABLE_EN
        // Byte-enable write: check mid-write and idle values
        repeat (2) @(negedge clk);
        req_we_n = 0; req_den = 1; req_address = 20'h00500; req_dout = 32'h11223344; req_be_n = 4'b1100;
        @(posedge clk);
        #1 set_idle();
        @(negedge clk);
        chk("be_write", sram_be_n, 4'b1100);
        repeat (5) @(negedge clk);
        chk("be_idle", sram_be_n, 4'b1111);
        req_be_n = 4'h0;
`endif

        // Priority: write wins when den=1
        do_access(0, 0, 1, 20'h00777, 32'hCAFEF00D, 4'h0, lat, wel, oel, cel);
        chk("prio_wr_lat", lat, 4);
        chk("prio_wr_we", wel, 2);
        chk("prio_wr_oe", oel, 0);
        // Priority: den=0 turns it into a read
        do_access(0, 0, 0, 20'h00777, 32'h0, 4'h0, lat, wel, oel, cel);
        chk("prio_rd_lat", lat, 3);
        chk("prio_rd_we", wel, 0);
        chk("prio_rd_oe", oel, 2);
        chk("prio_rd_data", res_din, 32'hCAFEF00D);

        // Renderer-style stream: address advances on done
        repeat (2) @(negedge clk);
        req_we_n = 0; req_oe_n = 1; req_den = 1; req_address = 20'h00200; req_dout = 32'hA5000000;
        cnt = 0; last_t = 0;
        for (int i = 0; i < 200 && cnt < 8; i++) begin
            @(posedge clk);
            #1;
            if (res_done) begin
                if (cnt > 0) chk("stream_gap", i - last_t, WE + 3);
                last_t = i;
                cnt++;
                if (cnt == 8) set_idle();
                else begin
                    req_address = req_address + 1;
                    req_dout = req_dout + 1;
                end
            end
        end
        set_idle();
        chk("stream_count", cnt, 8);
        for (int i = 0; i < 8; i++) begin
            logic [AW-1:0] a;
            a = 20'h00200 + AW'(i);
            chk("stream_mem", mem_rd(a), 32'hA5000000 + 32'(i));
        end

        // Reset during WR_PULSE
        repeat (3) @(negedge clk);
        req_we_n = 0; req_den = 1; req_address = 20'h00300; req_dout = 32'h12345678;
        @(posedge clk);
        #1 set_idle();
        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_ce_n", sram_ce_n, 1'b1);
        chk("abort_done", res_done, 1'b0);
        repeat (2) @(negedge clk);
        chk("abort_no_done", res_done, 1'b0);
        #2 rst = 1;
        do_access(1, 0, 0, 20'h00042, '0, 4'h0, lat, wel, oel, cel);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", res_din, 32'h0F0F00FF);

        // Randomized requests against the schedule model
        pool[0] = 20'h00042; pool[1] = 20'h00123; pool[2] = 20'hFFFFF; pool[3] = 20'h80001;
        for (int i = 4; i < 8; i++) pool[i] = AW'($urandom);
        for (int i = 0; i < 800; i++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 9);
            req_address = pool[$urandom_range(0, 7)];
            req_dout = $urandom;
`ifdef SRAM_BYTE_ENABLE_EN
            req_be_n = 4'($urandom);
`endif
            case (r)
                0, 1, 2, 3: set_idle();
                4, 5: begin req_we_n = 0; req_oe_n = 1'($urandom); req_den = 1; end
                6: begin req_we_n = 0; req_oe_n = 0; req_den = 0; end
                7: begin req_we_n = 0; req_oe_n = 1; req_den = 0; end
                default: begin req_we_n = 1; req_oe_n = 0; req_den = 1'($urandom); end
            endcase
        end
        @(negedge clk);
        set_idle();
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Responder side of the SRAM request/result interface. It accepts single-word read and write requests from one initiator, such as the font shape renderer or the scanout reader.
- It drives the external asynchronous SRAM pins with fixed, parameterised strobe timing.
- It returns a one-cycle done pulse and, for reads, the captured data word.
- One instance per physical SRAM bank; it sits between the arbiter mux and the board pins.

Parameters:
- ADDR_WIDTH, 20, word address width of the SRAM.
- DATA_WIDTH, 32, SRAM data bus width (multiple of 8).
- WE_CYCLES, 2, clocks the we_n pulse is held low; minimum 1.
- READ_CYCLES, 2, clocks oe_n is low before data capture; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- req_address  in  ADDR_WIDTH  request word address (SramRequest_t.address)
- req_dout  in  DATA_WIDTH  write data (SramRequest_t.dout)
- req_oe_n  in  1  0 = read request
- req_we_n  in  1  0 = write request
- req_den  in  1  1 = initiator permits bus drive; a write requires req_den=1
- res_done  out  1  one-cycle completion pulse (SramResult_t.done)
- res_din  out  DATA_WIDTH  read data, valid while res_done=1 after a read
- sram_addr  out  ADDR_WIDTH  SRAM address pins
- sram_data  inout  DATA_WIDTH  SRAM data pins, tri-stated unless writing
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes
- sram_be_n  out  DATA_WIDTH/8  byte enables

Behaviour:
- Request decode: write = ~req_we_n & req_den; read = ~req_oe_n & ~write. Write has priority when both are asserted. Neither means idle.
- Reset (async, rst=0):
  - FSM goes to IDLE immediately.
  - ce_n, oe_n, we_n = 1; be_n = all 1; sram_addr = 0; sram_data = Z; res_done = 0; res_din = 0.
  - Reset asserted mid-operation aborts the access with the same values. No done pulse is emitted for the aborted access.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT, RD_DONE.
- IDLE:
  - All strobes high; bus Z.
  - On a clock edge with write decoded: latch req_address and req_dout into internal registers, go to WR_SETUP.
  - On a clock edge with read decoded: latch the address, go to RD_WAIT.
- WR_SETUP (1 clk): ce_n=0, be_n=0, we_n=1; addr and data driven from latched registers. Next state WR_PULSE.
- WR_PULSE (WE_CYCLES clks): we_n=0 via a down-counter. Next state WR_HOLD.
- WR_HOLD (1 clk): we_n=1, ce_n=0, data still driven, res_done=1. Next state IDLE.
- Write latency: res_done is high on clock 2+WE_CYCLES after the accept edge.
- RD_WAIT (READ_CYCLES clks): ce_n=0, oe_n=0, be_n=0, bus Z. On the final wait edge, sram_data is registered into res_din. Next state RD_DONE.
- RD_DONE (1 clk): res_done=1, res_din valid, strobes high. Next state IDLE.
- Read latency: res_done is high on clock 1+READ_CYCLES after the accept edge.
- res_din holds its value until the next read capture. Writes do not change it.
- All SRAM outputs and res_done are registered (no combinational paths from req_* to pins).
- The initiator may change req_* in the same cycle res_done=1 (next-address lookahead). The controller ignores req_* outside IDLE because request fields are latched.
- Back-to-back requests: exactly one IDLE bubble between accesses, which provides the bus-turnaround cycle.
- An initiator that holds the same request continuously causes repeated accesses. Deasserting the request is the initiator's duty.
- WE_CYCLES=1 and READ_CYCLES=1 are legal; counter width is clog2(max+1).

Optional Feature:
- Macro: SRAM_BYTE_ENABLE_EN.
- Defined: adds input port req_be_n [DATA_WIDTH/8], latched at accept and driven on sram_be_n during WR_SETUP/PULSE/HOLD. Reads still use be_n=0.
- Undefined: no req_be_n port; sram_be_n is all 0 during any access and all 1 in IDLE.

Test Plan:
- Write: WE_CYCLES=2, req_address=0x00123, req_dout=0xDEADBEEF, we_n=0, den=1.
  -> sram_addr=0x00123 and data=0xDEADBEEF driven for 4 clks.
  -> we_n low exactly 2 clks, bounded by 1 setup and 1 hold clk.
  -> res_done high 1 clk, 4 clks after accept.
- Read: READ_CYCLES=2, SRAM model returns 0x0F0F00FF at 0x00042, oe_n=0.
  -> oe_n low 2 clks; bus Z throughout.
  -> res_done with res_din=0x0F0F00FF 3 clks after accept.
- Renderer-style stream: 8 consecutive writes with address incremented combinationally on res_done.
  -> 8 done pulses; SRAM model holds all 8 words at correct addresses.
  -> one IDLE cycle between accesses.
- Priority: we_n=0, oe_n=0, den=1 -> write performed, oe_n stays 1. Same with den=0 -> read performed.
- Reset during WR_PULSE: rst=0 asynchronously.
  -> we_n/ce_n go 1 and bus goes Z before the next clock edge; no res_done.
  -> after release, FSM is in IDLE and accepts a new read normally.
- SRAM_BYTE_ENABLE_EN: write with req_be_n=4'b1100 -> sram_be_n=1100 during the write, 1111 in IDLE.
